// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: next-PC select encodings,
// exception vectors, the NOP word and the instruction-fetch FSM states.
package mips_pkg;

    // Next-PC select driven by the decode stage; codes 6 and 7 act as PC+4
    typedef enum logic [2:0] {
        PCSRC_SEQ    = 3'd0,
        PCSRC_BRANCH = 3'd1,
        PCSRC_JUMP   = 3'd2,
        PCSRC_JR     = 3'd3,
        PCSRC_ILLOP  = 3'd4,
        PCSRC_XADR   = 3'd5
    } pcsrc_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC_DEFAULT = 32'h8000_0004;
    localparam logic [31:0] XADR_PC_DEFAULT  = 32'h8000_0008;

    localparam logic [31:0] NOP = '0;

    // Instruction-fetch controller states
    typedef enum logic [1:0] {
        IF_FETCH   = 2'd0,
        IF_HOLD    = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_e;

    // Sequential increment that never touches the supervisor bit
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    // True when the select code (with branch qualifier) changes the PC flow
    function automatic logic is_redirect_src(input logic [2:0] src,
                                             input logic       flush);
        return (src == PCSRC_JUMP) || (src == PCSRC_JR) ||
               (src == PCSRC_ILLOP) || (src == PCSRC_XADR) ||
               ((src == PCSRC_BRANCH) && flush);
    endfunction

endpackage

// File: rtl/pipeline_if_pc_next_sel.sv
// pc_next_sel: combinational next-PC logic for the fetch stage.
// Produces the sequential PC (supervisor bit preserved) and the redirect
// target selected by PCSrc, including the J/JAL region concatenation.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] ILLOP_PC = ILLOP_PC_DEFAULT,
    parameter logic [31:0] XADR_PC  = XADR_PC_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic [3:0]  id_pc_hi,
    input  logic [2:0]  pcsrc,
    input  logic [31:0] conba,
    input  logic [25:0] jt,
    input  logic [31:0] jr_target,
    output logic [31:0] seq_pc,
    output logic [31:0] target_pc
);

    // Sequential successor of the current fetch address
    always_comb begin
        seq_pc = pc_plus4(pc);
    end

    // Redirect target mux; non-redirect codes fall back to the sequential PC
    always_comb begin
        target_pc = seq_pc;
        case (pcsrc)
            PCSRC_BRANCH: target_pc = conba;
            PCSRC_JUMP:   target_pc = {id_pc_hi, jt, 2'b00};
            PCSRC_JR:     target_pc = jr_target;
            PCSRC_ILLOP:  target_pc = ILLOP_PC;
            PCSRC_XADR:   target_pc = XADR_PC;
            default:      target_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pipeline_if.sv
// pipeline_if: instruction-fetch stage. Holds the PC, issues one fetch at a
// time over a req/ack handshake and loads the IF/ID register. Absorbs
// load-use stalls with a one-entry skid register and drops fetches that are
// in flight when decode redirects the PC.
// Optional build macro: IF_DELAY_SLOT_EN keeps the delay-slot instruction on
// branch/jump redirects (PCSrc 1-3).
module pipeline_if
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] ILLOP_PC = ILLOP_PC_DEFAULT,
    parameter logic [31:0] XADR_PC  = XADR_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic        IFID_flush,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] JR_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instruction,
    output logic        ID_valid
);

    if_state_e   state;
    logic [31:0] pc;
    logic [31:0] skid;
    logic [31:0] redir_pc;
    logic [31:0] seq_pc;
    logic [31:0] target_pc;
    logic        redirect;
    logic        keep_slot;

    pc_next_sel #(
        .ILLOP_PC (ILLOP_PC),
        .XADR_PC  (XADR_PC)
    ) u_pc_next_sel (
        .pc        (pc),
        .id_pc_hi  (ID_PC[31:28]),
        .pcsrc     (PCSrc),
        .conba     (ConBA),
        .jt        (JT),
        .jr_target (JR_target),
        .seq_pc    (seq_pc),
        .target_pc (target_pc)
    );

    // Redirect qualification and delay-slot policy for the current cycle
    always_comb begin
        redirect = ID_valid && !stall && is_redirect_src(PCSrc, IFID_flush);
`ifdef IF_DELAY_SLOT_EN
        keep_slot = (PCSrc == PCSRC_BRANCH) || (PCSrc == PCSRC_JUMP) ||
                    (PCSrc == PCSRC_JR);
`else
        keep_slot = 1'b0;
`endif
    end

    // Memory request: the PC is always the address of the outstanding fetch;
    // gated by reset so nothing is requested while reset is held
    always_comb begin
        imem_req  = reset && (state != IF_HOLD);
        imem_addr = pc;
    end

    // Fetch FSM, PC, skid and IF/ID register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IF_FETCH;
            pc             <= RESET_PC;
            skid           <= NOP;
            redir_pc       <= RESET_PC;
            ID_PC          <= RESET_PC;
            ID_instruction <= NOP;
            ID_valid       <= 1'b0;
        end else begin
            case (state)
                IF_FETCH: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            pc <= target_pc;
                            if (keep_slot) begin
                                ID_PC          <= pc;
                                ID_instruction <= imem_rdata;
                                ID_valid       <= 1'b1;
                            end else begin
                                ID_instruction <= NOP;
                                ID_valid       <= 1'b0;
                            end
                        end else begin
                            // Old request must still complete; remember where to go
                            state          <= IF_DISCARD;
                            redir_pc       <= target_pc;
                            ID_instruction <= NOP;
                            ID_valid       <= 1'b0;
                        end
                    end else if (imem_ack) begin
                        if (stall) begin
                            skid  <= imem_rdata;
                            state <= IF_HOLD;
                        end else begin
                            ID_PC          <= pc;
                            ID_instruction <= imem_rdata;
                            ID_valid       <= 1'b1;
                            pc             <= seq_pc;
                        end
                    end else if (!stall) begin
                        ID_instruction <= NOP;
                        ID_valid       <= 1'b0;
                    end
                end
                IF_HOLD: begin
                    if (redirect) begin
                        pc    <= target_pc;
                        state <= IF_FETCH;
                        if (keep_slot) begin
                            ID_PC          <= pc;
                            ID_instruction <= skid;
                            ID_valid       <= 1'b1;
                        end else begin
                            ID_instruction <= NOP;
                            ID_valid       <= 1'b0;
                        end
                    end else if (!stall) begin
                        ID_PC          <= pc;
                        ID_instruction <= skid;
                        ID_valid       <= 1'b1;
                        pc             <= seq_pc;
                        state          <= IF_FETCH;
                    end
                end
                IF_DISCARD: begin
                    // IF/ID already holds a bubble; the late word is thrown away
                    if (imem_ack) begin
                        pc    <= redir_pc;
                        state <= IF_FETCH;
                    end
                end
                default: begin
                    state <= IF_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_if.sv
// Self-checking bench for pipeline_if: directed scenarios followed by a
// randomized run checked against an instruction-stream reference model.
module tb_pipeline_if;

    logic        clk;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        IFID_flush;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] JR_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ID_PC;
    logic [31:0] ID_instruction;
    logic        ID_valid;

    logic        ack_en;
    logic [31:0] xork;
    int unsigned compared;
    int unsigned mismatched;

    pipeline_if dut (
        .clk            (clk),
        .reset          (reset),
        .PCSrc          (PCSrc),
        .IFID_flush     (IFID_flush),
        .ConBA          (ConBA),
        .JT             (JT),
        .JR_target      (JR_target),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ID_PC          (ID_PC),
        .ID_instruction (ID_instruction),
        .ID_valid       (ID_valid)
    );

    // Memory model: acks combinationally when enabled; data is addr ^ xork
    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = imem_addr ^ xork;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; stall = 1'b0; PCSrc = 3'd0; IFID_flush = 1'b0;
        ConBA = '0; JT = '0; JR_target = '0; ack_en = 1'b1; xork = '0;
        tick; tick;
        compared++; if (ID_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", ID_valid); end
        compared++; if (ID_instruction !== 32'h0) begin mismatched++; $display("FAIL reset_instr: got %h want 0", ID_instruction); end
        compared++; if (ID_PC !== 32'h8000_0000) begin mismatched++; $display("FAIL reset_idpc: got %h want 80000000", ID_PC); end
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        reset = 1'b1; #1;
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL first_req: got %0b want 1", imem_req); end
        compared++; if (imem_addr !== 32'h8000_0000) begin mismatched++; $display("FAIL addr0: got %h want 80000000", imem_addr); end
        tick;
        compared++; if (imem_addr !== 32'h8000_0004) begin mismatched++; $display("FAIL addr1: got %h want 80000004", imem_addr); end
        compared++; if ({ID_valid, ID_PC, ID_instruction} !== {1'b1, 32'h8000_0000, 32'h8000_0000}) begin
            mismatched++; $display("FAIL first_id: got v=%0b pc=%h in=%h want v=1 pc=80000000 in=80000000", ID_valid, ID_PC, ID_instruction); end
        tick;
        compared++; if (imem_addr !== 32'h8000_0008) begin mismatched++; $display("FAIL addr2: got %h want 80000008", imem_addr); end
        compared++; if (ID_PC !== 32'h8000_0004) begin mismatched++; $display("FAIL second_id: got %h want 80000004", ID_PC); end
    endtask

    task automatic test_stall;
        tick; tick;
        compared++; if (imem_addr !== 32'h8000_0010) begin mismatched++; $display("FAIL stall_pre_addr: got %h want 80000010", imem_addr); end
        stall = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            tick;
            compared++; if ({imem_req, ID_valid, ID_PC} !== {1'b0, 1'b1, 32'h8000_000C}) begin
                mismatched++; $display("FAIL stall_hold%0d: got req=%0b v=%0b pc=%h want req=0 v=1 pc=8000000c", i, imem_req, ID_valid, ID_PC); end
        end
        stall = 1'b0; #1;
        tick;
        compared++; if ({ID_valid, ID_PC, ID_instruction} !== {1'b1, 32'h8000_0010, 32'h8000_0010}) begin
            mismatched++; $display("FAIL stall_release_id: got v=%0b pc=%h in=%h want v=1 pc=80000010 in=80000010", ID_valid, ID_PC, ID_instruction); end
        compared++; if ({imem_req, imem_addr} !== {1'b1, 32'h8000_0014}) begin
            mismatched++; $display("FAIL stall_resume: got req=%0b addr=%h want req=1 addr=80000014", imem_req, imem_addr); end
    endtask

    task automatic test_branch;
        PCSrc = 3'd1; IFID_flush = 1'b1; ConBA = 32'h8000_0100; #1;
        tick;
        PCSrc = 3'd0; IFID_flush = 1'b0; #1;
        compared++; if (imem_addr !== 32'h8000_0100) begin mismatched++; $display("FAIL branch_addr: got %h want 80000100", imem_addr); end
`ifdef IF_DELAY_SLOT_EN
        compared++; if ({ID_valid, ID_PC, ID_instruction} !== {1'b1, 32'h8000_0014, 32'h8000_0014}) begin
            mismatched++; $display("FAIL branch_slot: got v=%0b pc=%h in=%h want v=1 pc=80000014", ID_valid, ID_PC, ID_instruction); end
`else
        compared++; if ({ID_valid, ID_instruction} !== {1'b0, 32'h0}) begin
            mismatched++; $display("FAIL branch_bubble: got v=%0b in=%h want v=0 in=0", ID_valid, ID_instruction); end
`endif
        tick;
        compared++; if ({ID_valid, ID_PC, imem_addr} !== {1'b1, 32'h8000_0100, 32'h8000_0104}) begin
            mismatched++; $display("FAIL branch_target_id: got v=%0b pc=%h addr=%h want v=1 pc=80000100 addr=80000104", ID_valid, ID_PC, imem_addr); end
    endtask

    task automatic test_discard;
        ack_en = 1'b0; PCSrc = 3'd2; JT = 26'h40; #1;
        tick;
        PCSrc = 3'd0; #1;
        compared++; if ({imem_req, imem_addr, ID_valid} !== {1'b1, 32'h8000_0104, 1'b0}) begin
            mismatched++; $display("FAIL discard_wait1: got req=%0b addr=%h v=%0b want req=1 addr=80000104 v=0", imem_req, imem_addr, ID_valid); end
        tick;
        compared++; if ({imem_req, imem_addr} !== {1'b1, 32'h8000_0104}) begin
            mismatched++; $display("FAIL discard_wait2: got req=%0b addr=%h want req=1 addr=80000104", imem_req, imem_addr); end
        ack_en = 1'b1; #1;
        tick;
        compared++; if ({imem_addr, ID_valid} !== {32'h8000_0100, 1'b0}) begin
            mismatched++; $display("FAIL discard_drop: got addr=%h v=%0b want addr=80000100 v=0", imem_addr, ID_valid); end
        tick;
        compared++; if ({ID_valid, ID_PC, imem_addr} !== {1'b1, 32'h8000_0100, 32'h8000_0104}) begin
            mismatched++; $display("FAIL discard_target: got v=%0b pc=%h addr=%h want v=1 pc=80000100 addr=80000104", ID_valid, ID_PC, imem_addr); end
    endtask

    task automatic test_wrap;
        PCSrc = 3'd3; JR_target = 32'hFFFF_FFFC; #1;
        tick;
        PCSrc = 3'd0; #1;
        compared++; if (imem_addr !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL jr_addr: got %h want fffffffc", imem_addr); end
        tick;
        compared++; if ({ID_valid, ID_PC, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h8000_0000}) begin
            mismatched++; $display("FAIL wrap: got v=%0b pc=%h addr=%h want v=1 pc=fffffffc addr=80000000", ID_valid, ID_PC, imem_addr); end
    endtask

    task automatic test_xadr;
        tick;
        compared++; if ({ID_valid, ID_PC} !== {1'b1, 32'h8000_0000}) begin
            mismatched++; $display("FAIL xadr_pre: got v=%0b pc=%h want v=1 pc=80000000", ID_valid, ID_PC); end
        PCSrc = 3'd5; #1;
        tick;
        PCSrc = 3'd0; #1;
        compared++; if ({ID_valid, ID_instruction, imem_addr} !== {1'b0, 32'h0, 32'h8000_0008}) begin
            mismatched++; $display("FAIL xadr_redirect: got v=%0b in=%h addr=%h want v=0 in=0 addr=80000008", ID_valid, ID_instruction, imem_addr); end
        tick;
        compared++; if ({ID_valid, ID_PC} !== {1'b1, 32'h8000_0008}) begin
            mismatched++; $display("FAIL xadr_target: got v=%0b pc=%h want v=1 pc=80000008", ID_valid, ID_PC); end
    endtask

    task automatic test_midreset;
        ack_en = 1'b0; #1;
        tick;
        reset = 1'b0; #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL midreset_req: got %0b want 0", imem_req); end
        tick;
        reset = 1'b1; #1;
        compared++; if ({imem_req, imem_addr, ID_valid} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            mismatched++; $display("FAIL midreset_state: got req=%0b addr=%h v=%0b want req=1 addr=80000000 v=0", imem_req, imem_addr, ID_valid); end
        ack_en = 1'b1;
    endtask

    // Stream model: consecutive valid ID entries follow PC+4 (bit 31 kept)
    // unless a redirect intervened, in which case the next one is the target
    task automatic test_random;
        int unsigned consumed;
        logic [31:0] exp_pc, last_pc, prev_addr, p_pc, p_in, tgt;
        logic        p_v, prev_stall, prev_redir, prev_pend, redir;
        consumed = 0;
        reset = 1'b0; ack_en = 1'b0; stall = 1'b0; PCSrc = 3'd0; IFID_flush = 1'b0;
        xork = $urandom;
        tick;
        reset = 1'b1; #1;
        exp_pc = 32'h8000_0000; last_pc = exp_pc;
        prev_stall = 1'b0; prev_redir = 1'b0;
        prev_pend = imem_req && !imem_ack; prev_addr = imem_addr;
        p_v = ID_valid; p_pc = ID_PC; p_in = ID_instruction;
        for (int i = 0; i < 3000; i++) begin
            tick;
            if (prev_redir) begin
                compared++; if (ID_valid !== 1'b0) begin mismatched++; $display("FAIL rnd_bubble @%0d: got v=%0b want 0", i, ID_valid); end
            end else if (!prev_stall) begin
                if (ID_valid) begin
                    compared++; if ({ID_PC, ID_instruction} !== {exp_pc, exp_pc ^ xork}) begin
                        mismatched++; $display("FAIL rnd_stream @%0d: got pc=%h in=%h want pc=%h in=%h", i, ID_PC, ID_instruction, exp_pc, exp_pc ^ xork); end
                    consumed++;
                    last_pc = exp_pc;
                    exp_pc = {exp_pc[31], exp_pc[30:0] + 31'd4};
                end
            end else begin
                compared++; if ({ID_valid, ID_PC, ID_instruction} !== {p_v, p_pc, p_in}) begin
                    mismatched++; $display("FAIL rnd_stall_hold @%0d: got v=%0b pc=%h in=%h want v=%0b pc=%h in=%h", i, ID_valid, ID_PC, ID_instruction, p_v, p_pc, p_in); end
            end
            p_v = ID_valid; p_pc = ID_PC; p_in = ID_instruction;

            stall      = ($urandom_range(0, 3) == 0);
            ack_en     = ($urandom_range(0, 2) != 0);
            IFID_flush = 1'($urandom_range(0, 1));
            ConBA      = $urandom & 32'hFFFF_FFFC;
            JT         = 26'($urandom);
            JR_target  = $urandom & 32'hFFFF_FFFC;
            PCSrc      = (ID_valid && $urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
`ifdef IF_DELAY_SLOT_EN
            if (PCSrc >= 3'd1 && PCSrc <= 3'd3) PCSrc = 3'd0;
`endif
            #1;
            if (prev_pend && imem_req) begin
                compared++; if (imem_addr !== prev_addr) begin
                    mismatched++; $display("FAIL rnd_addr_stable @%0d: got %h want %h", i, imem_addr, prev_addr); end
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;

            redir = ID_valid && !stall &&
                    ((PCSrc >= 3'd2 && PCSrc <= 3'd5) || (PCSrc == 3'd1 && IFID_flush));
            if (redir) begin
                case (PCSrc)
                    3'd1:    tgt = ConBA;
                    3'd2:    tgt = {last_pc[31:28], JT, 2'b00};
                    3'd3:    tgt = JR_target;
                    3'd4:    tgt = 32'h8000_0004;
                    default: tgt = 32'h8000_0008;
                endcase
                exp_pc = tgt;
            end
            prev_redir = redir;
            prev_stall = stall;
        end
        PCSrc = 3'd0; stall = 1'b0; ack_en = 1'b1;
        compared++; if (consumed < 200) begin mismatched++; $display("FAIL rnd_throughput: got %0d instructions want >= 200", consumed); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset;
        test_stall;
        test_branch;
        test_discard;
        test_wrap;
        test_xadr;
        test_midreset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
